// File: rtl/ps2_rx_fifo_if.sv
// Output queue handshake between ps2_rx_fifo and its consumer.
// Latency: none, this is plain wiring.
// Backpressure: the consumer holds m_ready low to stall the queue head.
interface ps2_rx_fifo_if;
  logic       m_valid;
  logic       m_ready;
  logic [7:0] m_data;
  logic [1:0] m_flags;

  modport master (output m_valid, output m_data, output m_flags, input m_ready);
  modport slave  (input m_valid, input m_data, input m_flags, output m_ready);
endinterface

// File: rtl/ps2_rx_fifo.sv
// PS/2 device-to-host receiver: sync + glitch filter, frame FSM with watchdog, output queue.
// Latency: byte is queued on the edge ending the stop-bit fall cycle; m_valid one cycle later.
// Backpressure: queue holds FIFO_DEPTH bytes; a good byte arriving while full drops and pulses overflow.
// Optional prefix merging (E0/F0 folded into m_flags) is enabled by defining PS2_PREFIX_MERGE_EN.
module ps2_rx_fifo #(
  parameter int FILTER_LEN  = 4,
  parameter int TIMEOUT_CYC = 200000,
  parameter int FIFO_DEPTH  = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          ps2clk,
  input  logic                          ps2data,
  ps2_rx_fifo_if.master                 m_bus,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          parity_err,
  output logic                          frame_err,
  output logic                          timeout_err,
  output logic                          overflow
);

  localparam int PW  = $clog2(FIFO_DEPTH);
  localparam int CW  = PW + 1;
  localparam int WDW = $clog2(TIMEOUT_CYC);
  localparam logic [3:0]     FL_MAX = 4'(FILTER_LEN - 1);
  localparam logic [WDW-1:0] TO_MAX = WDW'(TIMEOUT_CYC - 1);
  localparam logic [CW-1:0]  FULL_CNT = CW'(FIFO_DEPTH);
`ifdef PS2_PREFIX_MERGE_EN
  localparam int EW = 10;
`else
  localparam int EW = 8;
`endif

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  // input conditioning
  logic       clk_s1, clk_s2, dat_s1, dat_s2;
  logic       clk_f, dat_f, clk_f_q;
  logic [3:0] clk_cnt, dat_cnt;
  logic       fall;

  // frame FSM
  state_t         state;
  logic [7:0]     shreg;
  logic [2:0]     bit_cnt;
  logic           ones_par;   // only the parity of the ones count matters
  logic           parity_ok;
  logic [WDW-1:0] wd_cnt;
`ifdef PS2_PREFIX_MERGE_EN
  logic           pend_ext, pend_brk;
`endif

  // queue
  logic [EW-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic          good_stop, push_req, wr_en, pop, full, q_valid;
  logic [EW-1:0] push_dat;

  // 2-FF synchronisers and per-line consecutive-sample filters
  always_ff @(posedge clk) begin
    if (reset) begin
      clk_s1  <= 1'b1;
      clk_s2  <= 1'b1;
      dat_s1  <= 1'b1;
      dat_s2  <= 1'b1;
      clk_f   <= 1'b1;
      dat_f   <= 1'b1;
      clk_f_q <= 1'b1;
      clk_cnt <= 4'd0;
      dat_cnt <= 4'd0;
    end else begin
      clk_s1  <= ps2clk;
      clk_s2  <= clk_s1;
      dat_s1  <= ps2data;
      dat_s2  <= dat_s1;
      clk_f_q <= clk_f;
      if (clk_s2 == clk_f) begin
        clk_cnt <= 4'd0;
      end else if (clk_cnt == FL_MAX) begin
        clk_f   <= clk_s2;
        clk_cnt <= 4'd0;
      end else begin
        clk_cnt <= clk_cnt + 4'd1;
      end
      if (dat_s2 == dat_f) begin
        dat_cnt <= 4'd0;
      end else if (dat_cnt == FL_MAX) begin
        dat_f   <= dat_s2;
        dat_cnt <= 4'd0;
      end else begin
        dat_cnt <= dat_cnt + 4'd1;
      end
    end
  end

  assign fall = clk_f_q & ~clk_f;

  assign good_stop = (state == STOP) && fall && dat_f && parity_ok;
`ifdef PS2_PREFIX_MERGE_EN
  assign push_req = good_stop && (shreg != 8'hE0) && (shreg != 8'hF0);
  assign push_dat = {pend_brk, pend_ext, shreg};
`else
  assign push_req = good_stop;
  assign push_dat = shreg;
`endif

  // frame FSM, watchdog and registered parity/frame/timeout pulses
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      shreg       <= 8'h00;
      bit_cnt     <= 3'd0;
      ones_par    <= 1'b0;
      parity_ok   <= 1'b0;
      wd_cnt      <= '0;
      parity_err  <= 1'b0;
      frame_err   <= 1'b0;
      timeout_err <= 1'b0;
`ifdef PS2_PREFIX_MERGE_EN
      pend_ext    <= 1'b0;
      pend_brk    <= 1'b0;
`endif
    end else begin
      parity_err  <= 1'b0;
      frame_err   <= 1'b0;
      timeout_err <= 1'b0;

      // watchdog: a fall and an expiry never coincide, so the case below cannot conflict
      if (state == IDLE || fall) begin
        wd_cnt <= '0;
      end else if (wd_cnt == TO_MAX) begin
        wd_cnt      <= '0;
        state       <= IDLE;
        timeout_err <= 1'b1;
`ifdef PS2_PREFIX_MERGE_EN
        pend_ext    <= 1'b0;
        pend_brk    <= 1'b0;
`endif
      end else begin
        wd_cnt <= wd_cnt + WDW'(1);
      end

      if (fall) begin
        case (state)
          IDLE: begin
            if (!dat_f) begin
              state    <= DATA;
              bit_cnt  <= 3'd0;
              ones_par <= 1'b0;
            end
          end
          DATA: begin
            shreg    <= {dat_f, shreg[7:1]};
            ones_par <= ones_par ^ dat_f;
            bit_cnt  <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) state <= PARITY;
          end
          PARITY: begin
            parity_ok <= ones_par ^ dat_f;
            state     <= STOP;
          end
          STOP: begin
            state <= IDLE;
            if (!dat_f) begin
              frame_err <= 1'b1;
`ifdef PS2_PREFIX_MERGE_EN
              pend_ext  <= 1'b0;
              pend_brk  <= 1'b0;
`endif
            end else if (!parity_ok) begin
              parity_err <= 1'b1;
`ifdef PS2_PREFIX_MERGE_EN
              pend_ext   <= 1'b0;
              pend_brk   <= 1'b0;
`endif
            end else begin
`ifdef PS2_PREFIX_MERGE_EN
              // a pushed or overflow-dropped byte both consume the pending prefixes
              if (shreg == 8'hE0) begin
                pend_ext <= 1'b1;
              end else if (shreg == 8'hF0) begin
                pend_brk <= 1'b1;
              end else begin
                pend_ext <= 1'b0;
                pend_brk <= 1'b0;
              end
`endif
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign q_valid = (count != '0);
  assign full    = (count == FULL_CNT);
  assign pop     = q_valid && m_bus.m_ready;
  assign wr_en   = push_req && (!full || pop);

  // queue pointers, occupancy and overflow pulse
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      overflow <= push_req && full && !pop;
      if (wr_en) wr_ptr <= wr_ptr + PW'(1);
      if (pop)   rd_ptr <= rd_ptr + PW'(1);
      case ({wr_en, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // queue storage; contents need no reset because the head is masked when empty
  always_ff @(posedge clk) begin
    if (!reset && wr_en) mem[wr_ptr] <= push_dat;
  end

  assign m_bus.m_valid = q_valid;
  assign m_bus.m_data  = q_valid ? mem[rd_ptr][7:0] : 8'h00;
`ifdef PS2_PREFIX_MERGE_EN
  assign m_bus.m_flags = q_valid ? mem[rd_ptr][9:8] : 2'b00;
`else
  assign m_bus.m_flags = 2'b00;
`endif
  assign fifo_count = count;

endmodule

// File: tb/tb_ps2_rx_fifo.sv
// Scoreboard bench for ps2_rx_fifo: frames are bit-banged on the PS/2 lines, expected bytes
// and error pulses are queued by the stimulus and popped by an independent monitor.
module tb_ps2_rx_fifo;
  localparam int FL    = 4;
  localparam int TO    = 300;
  localparam int DEPTH = 8;
  localparam int HALF  = 20;
  localparam int E_PAR = 0, E_FRM = 1, E_TO = 2, E_OVF = 3;

  logic       clk = 1'b0;
  logic       reset;
  logic       ps2clk, ps2data;
  logic [3:0] fifo_count;
  logic       perr, ferr, terr, ovf;

  ps2_rx_fifo_if bus ();

  ps2_rx_fifo #(.FILTER_LEN(FL), .TIMEOUT_CYC(TO), .FIFO_DEPTH(DEPTH)) dut (
    .clk         (clk),
    .reset       (reset),
    .ps2clk      (ps2clk),
    .ps2data     (ps2data),
    .m_bus       (bus.master),
    .fifo_count  (fifo_count),
    .parity_err  (perr),
    .frame_err   (ferr),
    .timeout_err (terr),
    .overflow    (ovf)
  );

  always #5 clk = ~clk;

  logic [9:0] exp_q[$];
  int         err_q[$];
  int         n_checks = 0;
  int         n_fail   = 0;
  bit         pend_ext = 1'b0;
  bit         pend_brk = 1'b0;
  logic [9:0] mon_e;
  int         mon_k;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // reference for a correctly received byte
  task automatic expect_good(input logic [7:0] b);
`ifdef PS2_PREFIX_MERGE_EN
    if (b == 8'hE0) pend_ext = 1'b1;
    else if (b == 8'hF0) pend_brk = 1'b1;
    else begin
      exp_q.push_back({pend_brk, pend_ext, b});
      pend_ext = 1'b0;
      pend_brk = 1'b0;
    end
`else
    exp_q.push_back({2'b00, b});
`endif
  endtask

  task automatic drive_bit(input logic v);
    ps2data = v;
    tick(HALF / 2);
    ps2clk = 1'b0;
    tick(HALF);
    ps2clk = 1'b1;
    tick(HALF / 2);
  endtask

  task automatic send_frame(input logic [7:0] b, input bit bad_par, input logic stop, input bit ovf_exp);
    logic [10:0] bits;
    bits = {stop, (~^b) ^ bad_par, b, 1'b0};
    for (int i = 0; i < 11; i++) begin
      if (i == 10) begin
        if (!stop) begin
          err_q.push_back(E_FRM); pend_ext = 1'b0; pend_brk = 1'b0;
        end else if (bad_par) begin
          err_q.push_back(E_PAR); pend_ext = 1'b0; pend_brk = 1'b0;
        end else if (ovf_exp) begin
          err_q.push_back(E_OVF); pend_ext = 1'b0; pend_brk = 1'b0;
        end else begin
          expect_good(b);
        end
      end
      drive_bit(bits[i]);
    end
    ps2data = 1'b1;
    tick(60);
  endtask

  // start bit plus n-1 data bits, then the lines are left idle
  task automatic send_partial(input int n);
    logic [7:0] pat;
    pat = 8'b1010_1010;
    for (int i = 0; i < n; i++) drive_bit(pat[i]);
    ps2data = 1'b1;
  endtask

  task automatic err_event(input int code);
    if (err_q.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL unexpected_err: got kind %0d, expected no error", code);
    end else begin
      mon_k = err_q.pop_front();
      check("err_kind", code, mon_k);
    end
  endtask

  // monitor: compares every accepted head and every error pulse against the queues
  always @(negedge clk) begin
    if (!reset) begin
      if (bus.m_valid && bus.m_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_byte: got 0x%0h, expected none", {bus.m_flags, bus.m_data});
        end else begin
          mon_e = exp_q.pop_front();
          check("rx_byte", {22'd0, bus.m_flags, bus.m_data}, {22'd0, mon_e});
        end
      end
      if (perr) err_event(E_PAR);
      if (ferr) err_event(E_FRM);
      if (terr) err_event(E_TO);
      if (ovf)  err_event(E_OVF);
    end
  end

  initial begin
    repeat (80000) @(posedge clk);
    $display("FAIL global_timeout: got no end of test, expected completion");
    $fatal(1, "simulation bound exceeded");
  end

  initial begin
    reset       = 1'b1;
    ps2clk      = 1'b1;
    ps2data     = 1'b1;
    bus.m_ready = 1'b0;
    tick(4);
    check("rst_m_valid", bus.m_valid, 0);
    check("rst_m_data", bus.m_data, 0);
    check("rst_m_flags", bus.m_flags, 0);
    check("rst_count", fifo_count, 0);
    check("rst_errs", {perr, ferr, terr, ovf}, 0);
    reset = 1'b0;
    tick(5);

    // basic receive, then a parity fault followed by a clean frame
    bus.m_ready = 1'b1;
    send_frame(8'h1C, 1'b0, 1'b1, 1'b0);
    check("count_after_1c", fifo_count, 0);
    send_frame(8'h1C, 1'b1, 1'b1, 1'b0);
    check("count_after_par", fifo_count, 0);
    send_frame(8'h32, 1'b0, 1'b1, 1'b0);

    // watchdog abort after four falls, then recovery
    err_q.push_back(E_TO);
    send_partial(4);
    tick(TO + 50);
    send_frame(8'h45, 1'b0, 1'b1, 1'b0);

    // clock glitch one sample short of the filter length, with data low
    ps2data = 1'b0;
    ps2clk  = 1'b0;
    tick(FL - 1);
    ps2clk = 1'b1;
    tick(TO + 100);
    ps2data = 1'b1;
    tick(10);

    // framing error
    send_frame(8'h5A, 1'b0, 1'b0, 1'b0);
    check("count_after_frm", fifo_count, 0);

    // fill past capacity, then drain in order
    bus.m_ready = 1'b0;
    for (int i = 1; i <= 9; i++) send_frame(8'(i), 1'b0, 1'b1, i == 9);
    check("full_count", fifo_count, DEPTH);
    check("full_valid", bus.m_valid, 1);
    check("full_head", bus.m_data, 8'h01);
    bus.m_ready = 1'b1;
    tick(20);
    check("drained_count", fifo_count, 0);
    check("drained_data", bus.m_data, 0);

    // reset mid-frame with a non-empty queue
    bus.m_ready = 1'b0;
    send_frame(8'h11, 1'b0, 1'b1, 1'b0);
    send_frame(8'h22, 1'b0, 1'b1, 1'b0);
    check("pre_rst_count", fifo_count, 2);
    send_partial(5);
    reset = 1'b1;
    tick(1);
    check("mid_rst_count", fifo_count, 0);
    check("mid_rst_valid", bus.m_valid, 0);
    exp_q.delete();
    err_q.delete();
    pend_ext = 1'b0;
    pend_brk = 1'b0;
    reset = 1'b0;
    tick(20);
    bus.m_ready = 1'b1;
    send_frame(8'h66, 1'b0, 1'b1, 1'b0);

    // prefix bytes: merged into one flagged entry when enabled, raw otherwise
    bus.m_ready = 1'b0;
    send_frame(8'hE0, 1'b0, 1'b1, 1'b0);
    send_frame(8'hF0, 1'b0, 1'b1, 1'b0);
    send_frame(8'h75, 1'b0, 1'b1, 1'b0);
`ifdef PS2_PREFIX_MERGE_EN
    check("merge_count", fifo_count, 1);
`else
    check("raw_count", fifo_count, 3);
`endif
    bus.m_ready = 1'b1;
    tick(10);
    send_frame(8'h75, 1'b0, 1'b1, 1'b0);
    tick(50);

    check("exp_q_empty", exp_q.size(), 0);
    check("err_q_empty", err_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
